// File: rtl/seven_seg_decoder.sv
// Hex nibble to seven-segment decoder for one display digit.
// The output is optionally registered and can be set to either drive polarity.
module seven_seg_decoder #(
  parameter int ACTIVE_LOW = 1,
  parameter int REGISTERED = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  output logic [6:0] result
);

  // Glyphs in active-low gfedcba form. An X/Z nibble matches no item and falls to blank.
  function automatic logic [6:0] glyph_al(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  function automatic logic [6:0] apply_polarity(input logic [6:0] seg_al);
    return (ACTIVE_LOW != 0) ? seg_al : ~seg_al;
  endfunction

  logic [6:0] w_seg;
  assign w_seg = apply_polarity(glyph_al(a));

  generate
    if (REGISTERED != 0) begin : g_reg
      localparam logic [6:0] BLANK = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
      logic [6:0] r_result;

      // Output stage: one cycle of latency, blanked asynchronously by reset
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_result <= BLANK;
        else     r_result <= w_seg;
      end

      assign result = r_result;
    end else begin : g_comb
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign result   = w_seg;
    end
  endgenerate

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Scoreboard bench for seven_seg_decoder: registered active-low, registered
// active-high and combinational instances against a lit-segment reference model.
module tb_seven_seg_decoder;

  logic       clk = 1'b0;
  bit         clk_en = 1'b0;
  logic       rst;
  logic [3:0] a;
  logic [3:0] a_c;
  logic [6:0] res_al;
  logic [6:0] res_ah;
  logic [6:0] res_comb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 if (clk_en) clk = ~clk;

  seven_seg_decoder u_al (
    .clk(clk), .rst(rst), .a(a), .result(res_al)
  );

  seven_seg_decoder #(.ACTIVE_LOW(0)) u_ah (
    .clk(clk), .rst(rst), .a(a), .result(res_ah)
  );

  seven_seg_decoder #(.REGISTERED(0)) u_comb (
    .clk(clk), .rst(rst), .a(a_c), .result(res_comb)
  );

  // Lit segments for each glyph, named by segment letter.
  string glyph [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                        "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                        "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] model(input logic [3:0] n, input bit active_low);
    logic [6:0] lit;
    string s;
    int k;
    lit = '0;
    s = glyph[n];
    for (int i = 0; i < s.len(); i++) begin
      k = int'(s[i]) - 97;
      lit[3'(k)] = 1'b1;
    end
    return active_low ? ~lit : lit;
  endfunction

  typedef struct {
    logic [3:0] nib;
    logic [6:0] exp_al;
    logic [6:0] exp_ah;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [3:0] v);
    sb.push_back('{nib: v, exp_al: model(v, 1'b1), exp_ah: model(v, 1'b0)});
  endtask

  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    a   = v;
    a_c = v;
    push_exp(v);
    #1 check("comb_follow", res_comb, model(v, 1'b1));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 10) begin
      @(posedge clk);
      #2;
      k++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every registered output is compared one edge after its input was issued
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check($sformatf("al_nib%h", e.nib), res_al, e.exp_al);
        check($sformatf("ah_nib%h", e.nib), res_ah, e.exp_ah);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a   = 4'h5;
    a_c = 4'h5;
    #2;
    check("reset_al", res_al, 7'h7F);
    check("reset_ah", res_ah, 7'h00);
    check("comb_ignores_rst", res_comb, 7'h12);

    a_c = 4'h0;
    #1 check("comb_0", res_comb, 7'h40);
    a_c = 4'hF;
    #1 check("comb_F", res_comb, 7'h0E);

    rst = 1'b0;
    #1 check("no_edge_after_rst", res_al, 7'h7F);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_al", res_al, 7'h12);
    check("first_edge_ah", res_ah, 7'h6D);

    for (int v = 0; v < 16; v++) drive(4'(v));
    drive({2'b00, 2'b11});
    drive({2'b00, 2'b10});
    repeat (20) drive({2'b00, 2'($urandom_range(3))});
    repeat (200) drive(4'($urandom_range(15)));
    drain();

    drive(4'hA);
    drive(4'hB);
    drive(4'hC);
    drain();
    #1 rst = 1'b1;
    #1;
    check("midrun_rst_al", res_al, 7'h7F);
    check("midrun_rst_ah", res_ah, 7'h00);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_al", res_al, 7'h7F);
    @(negedge clk);
    rst = 1'b0;
    a   = 4'h9;
    push_exp(4'h9);
    #1 check("rst_drop_no_edge", res_al, 7'h7F);
    drain();
    drive(4'h1);
    drive(4'h8);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
